// File: rtl/flash_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : flash_read_sequencer
// Purpose  : SPI-flash READ (0x03) engine for 6809 ROM-window byte reads; CS is
//            held low after a read so the next sequential byte streams on.
// Revision : 1.0  initial release
// ============================================================================
module flash_read_sequencer #(
  parameter int          CLK_DIV     = 1,
  parameter int          ADDR_BITS   = 12,
  parameter logic [23:0] FLASH_BASE  = 24'h000000,
  parameter int          HOLD_CYCLES = 255,
  parameter int          CS_HIGH_MIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_req,
  input  logic [15:0] i_ADDRESS_BUS,
  output logic [7:0]  o_DATA,
  output logic        o_data_valid,
  output logic        o_busy,
  output logic        o_MemoryReady,
  output logic        o_SPI_CLK,
  output logic        o_SPI_MOSI,
  output logic        o_SPI_CS,
  input  logic        i_SPI_MISO
);

  localparam int c_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_IDLE_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int c_DES_W  = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_LAST    = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_IDLE_W-1:0] c_HOLD_LAST   = c_IDLE_W'(HOLD_CYCLES - 1);
  localparam logic [c_DES_W-1:0]  c_DES_LAST    = c_DES_W'(CS_HIGH_MIN - 1);
  localparam logic [15:0]         c_OFFSET_MASK = 16'((32'd1 << ADDR_BITS) - 32'd1);
  localparam logic [7:0]          c_CMD_READ    = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_CMD      = 3'd2,
    S_DATA     = 3'd3,
    S_HOLD     = 3'd4,
    S_DESELECT = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_cs;
  logic                r_sclk;
  logic                r_mosi;
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_busy;
  logic                r_mrdy;
  logic [30:0]         r_sh;
  logic [6:0]          r_rx;
  logic [4:0]          r_bit;
  logic [c_DIV_W-1:0]  r_div;
  logic [c_IDLE_W-1:0] r_idle;
  logic [c_DES_W-1:0]  r_dcnt;
  logic [23:0]         r_fa;
  logic [23:0]         r_next_fa;
  logic                r_pend;
  logic [23:0]         r_pend_fa;

  logic [15:0] w_offset;
  logic [23:0] w_fa;
  logic [23:0] w_start_fa;
  logic [31:0] w_start_cmd;
  logic        w_des_done;
  logic        w_start;

  assign w_offset    = i_ADDRESS_BUS & c_OFFSET_MASK;
  assign w_fa        = FLASH_BASE + {8'h00, w_offset};
  assign w_des_done  = (r_dcnt == c_DES_LAST);
  // A request arriving in the last DESELECT cycle overrides the pending slot.
  assign w_start_fa  = (r_state == S_DESELECT && !i_req) ? r_pend_fa : w_fa;
  assign w_start_cmd = {c_CMD_READ, w_start_fa};
  assign w_start     = (r_state == S_IDLE && i_req) ||
                       (r_state == S_DESELECT && w_des_done && (r_pend || i_req));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_mrdy    <= 1'b1;
      r_sh      <= '0;
      r_rx      <= '0;
      r_bit     <= '0;
      r_div     <= '0;
      r_idle    <= '0;
      r_dcnt    <= '0;
      r_fa      <= '0;
      r_next_fa <= '0;
      r_pend    <= 1'b0;
      r_pend_fa <= '0;
    end else if (!i_enable) begin
      r_state <= S_IDLE;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_mrdy  <= 1'b1;
      r_pend  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_SETUP: begin
          r_state <= S_CMD;
          r_div   <= '0;
          r_bit   <= '0;
        end
        S_CMD, S_DATA: begin
          if (r_div != c_DIV_LAST) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              r_bit  <= r_bit + 1'b1;
              if (r_state == S_CMD) begin
                r_mosi <= r_sh[30];
                r_sh   <= {r_sh[29:0], 1'b0};
                if (r_bit == 5'd31) begin
                  r_state <= S_DATA;
                  r_mosi  <= 1'b0;
                  r_bit   <= '0;
                end
              end else begin
                r_rx <= {r_rx[5:0], i_SPI_MISO};
                if (r_bit == 5'd7) begin
                  r_state   <= S_HOLD;
                  r_data    <= {r_rx, i_SPI_MISO};
                  r_valid   <= 1'b1;
                  r_busy    <= 1'b0;
                  r_mrdy    <= 1'b1;
                  r_next_fa <= r_fa + 24'd1;
                  r_idle    <= '0;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (i_req) begin
            r_busy <= 1'b1;
            r_mrdy <= 1'b0;
            if (w_fa == r_next_fa) begin
              // Flash is still streaming: just clock out the next byte.
              r_state <= S_DATA;
              r_fa    <= w_fa;
              r_div   <= '0;
              r_bit   <= '0;
            end else begin
              r_state   <= S_DESELECT;
              r_cs      <= 1'b1;
              r_dcnt    <= '0;
              r_pend    <= 1'b1;
              r_pend_fa <= w_fa;
            end
          end else if (r_idle == c_HOLD_LAST) begin
            r_state <= S_DESELECT;
            r_cs    <= 1'b1;
            r_dcnt  <= '0;
          end else begin
            r_idle <= r_idle + 1'b1;
          end
        end
        S_DESELECT: begin
          if (i_req) begin
            r_pend    <= 1'b1;
            r_pend_fa <= w_fa;
            r_busy    <= 1'b1;
            r_mrdy    <= 1'b0;
          end
          if (w_des_done) r_state <= S_IDLE;
          else            r_dcnt  <= r_dcnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_start) begin
        r_state <= S_SETUP;
        r_cs    <= 1'b0;
        r_sclk  <= 1'b0;
        r_mosi  <= w_start_cmd[31];
        r_sh    <= w_start_cmd[30:0];
        r_fa    <= w_start_fa;
        r_pend  <= 1'b0;
        r_busy  <= 1'b1;
        r_mrdy  <= 1'b0;
      end
    end
  end

  assign o_DATA        = r_data;
  assign o_data_valid  = r_valid;
  assign o_busy        = r_busy;
  assign o_MemoryReady = r_mrdy;
  assign o_SPI_CLK     = r_sclk;
  assign o_SPI_MOSI    = r_mosi;
  assign o_SPI_CS      = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_flash_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_read_sequencer
// Purpose  : Self-checking bench: behavioural SPI flash plus a transaction-level
//            latency/continuation model for flash_read_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_flash_read_sequencer;

  localparam int          CLK_DIV     = 1;
  localparam int          HOLD_CYCLES = 255;
  localparam int          CS_HIGH_MIN = 2;
  localparam logic [23:0] FLASH_BASE  = 24'h000000;
  localparam int          LAT_NEW     = 2 + 80 * CLK_DIV;
  localparam int          LAT_CONT    = 1 + 16 * CLK_DIV;
  localparam int          LAT_MISS    = LAT_NEW + CS_HIGH_MIN;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic        i_req;
  logic [15:0] i_ADDRESS_BUS;
  logic [7:0]  o_DATA;
  logic        o_data_valid;
  logic        o_busy;
  logic        o_MemoryReady;
  logic        o_SPI_CLK;
  logic        o_SPI_MOSI;
  logic        o_SPI_CS;
  logic        i_SPI_MISO = 1'b0;

  flash_read_sequencer #(
    .CLK_DIV(CLK_DIV), .ADDR_BITS(12), .FLASH_BASE(FLASH_BASE),
    .HOLD_CYCLES(HOLD_CYCLES), .CS_HIGH_MIN(CS_HIGH_MIN)
  ) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_req(i_req),
    .i_ADDRESS_BUS(i_ADDRESS_BUS), .o_DATA(o_DATA), .o_data_valid(o_data_valid),
    .o_busy(o_busy), .o_MemoryReady(o_MemoryReady), .o_SPI_CLK(o_SPI_CLK),
    .o_SPI_MOSI(o_SPI_MOSI), .o_SPI_CS(o_SPI_CS), .i_SPI_MISO(i_SPI_MISO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Behavioural SPI flash: decodes the command from MOSI, streams mem[] out.
  logic [7:0]  mem [4096];
  logic [31:0] f_sh = '0;
  logic [31:0] f_last_cmd = '0;
  int          f_cnt = 0;
  int          f_cmds = 0;
  int          cs_rises = 0;

  always @(posedge o_SPI_CS) begin
    f_cnt = 0;
    cs_rises++;
  end

  always @(posedge o_SPI_CLK) begin
    if (!o_SPI_CS) begin
      if (f_cnt < 32) begin
        f_sh = {f_sh[30:0], o_SPI_MOSI};
        if (f_cnt == 31) begin
          f_last_cmd = f_sh;
          f_cmds++;
        end
      end
      f_cnt++;
    end
  end

  always @(negedge o_SPI_CLK) begin : flash_out
    logic [11:0] a;
    logic [7:0]  b;
    if (!o_SPI_CS && f_cnt >= 32) begin
      a = f_last_cmd[11:0] + 12'((f_cnt - 32) / 8);
      b = mem[a];
      i_SPI_MISO = b[3'(7 - ((f_cnt - 32) % 8))];
    end
  end

  // Length of the most recent completed CS-high interval, in clk cycles.
  int hi_run  = 0;
  int last_hi = 0;
  always @(posedge clk) begin
    #1;
    if (o_SPI_CS) hi_run++;
    else begin
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
    end
  end

  // Transaction-level model: is the engine parked in HOLD, and on which byte.
  bit          m_hold   = 0;
  logic [23:0] m_next   = '0;
  int          m_tvalid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [15:0] addr);
    logic [23:0] fa;
    bit          in_hold, cont, hs_ok;
    int          lat, n, cmds0, rises0, t0;
    fa = FLASH_BASE + 24'(addr[11:0]);
    @(posedge clk); #1;
    t0      = cyc;
    in_hold = m_hold && ((t0 - m_tvalid) < HOLD_CYCLES);
    cont    = in_hold && (fa == m_next);
    lat     = cont ? LAT_CONT : (in_hold ? LAT_MISS : LAT_NEW);
    cmds0   = f_cmds;
    rises0  = cs_rises;
    i_ADDRESS_BUS = addr;
    i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    n = 1;
    hs_ok = 1;
    while (!o_data_valid && n < 400) begin
      if (o_MemoryReady !== 1'b0 || o_busy !== 1'b1) hs_ok = 0;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("data", o_DATA, mem[fa[11:0]]);
    chk("mrdy_low_while_busy", 32'(hs_ok), 1);
    chk("mrdy_at_valid", o_MemoryReady, 1);
    chk("busy_at_valid", o_busy, 0);
    chk("new_commands", f_cmds - cmds0, cont ? 0 : 1);
    if (!cont) chk("command_word", f_last_cmd, {8'h03, fa});
    chk("cs_rises", cs_rises - rises0, (in_hold && !cont) ? 1 : 0);
    if (in_hold && !cont) chk("cs_high_len", last_hi, CS_HIGH_MIN);
    m_hold   = 1;
    m_next   = fa + 24'd1;
    m_tvalid = cyc;
  endtask

  initial begin : main
    logic [15:0] prev;
    logic [7:0]  d0;
    int          n;
    bit          seen;

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;

    reset = 1'b1; i_enable = 1'b1; i_req = 1'b0; i_ADDRESS_BUS = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", o_SPI_CS, 1);
    chk("rst_sclk", o_SPI_CLK, 0);
    chk("rst_mosi", o_SPI_MOSI, 0);
    chk("rst_data", o_DATA, 0);
    chk("rst_valid", o_data_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_mrdy", o_MemoryReady, 1);
    reset = 1'b0;

    // First read, sequential continuation, then window wrap.
    do_read(16'hF000);
    do_read(16'hF001);
    do_read(16'hFFFF);
    do_read(16'hF000);

    // HOLD timeout deselects; the next adjacent byte needs a full command.
    do_read(16'hF010);
    n = 0;
    while (!o_SPI_CS && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_rise_window", 32'((n >= HOLD_CYCLES - 2) && (n <= HOLD_CYCLES + 2)), 1);
    repeat (10) @(posedge clk);
    do_read(16'hF011);

    // Drop enable part-way through the command phase.
    @(posedge clk); #1;
    i_ADDRESS_BUS = 16'hF123; i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    d0 = o_DATA;
    i_enable = 1'b0;
    @(posedge clk); #1;
    chk("en_cs", o_SPI_CS, 1);
    chk("en_sclk", o_SPI_CLK, 0);
    chk("en_busy", o_busy, 0);
    chk("en_mrdy", o_MemoryReady, 1);
    seen = o_data_valid;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_data_valid) seen = 1;
    end
    chk("en_no_valid", 32'(seen), 0);
    chk("en_data_held", o_DATA, d0);
    i_enable = 1'b1;
    m_hold = 0;
    do_read(16'hF124);

    // Reset during the DATA phase.
    @(posedge clk); #1;
    i_ADDRESS_BUS = 16'hF200; i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    repeat (74) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_cs", o_SPI_CS, 1);
    chk("mid_rst_sclk", o_SPI_CLK, 0);
    chk("mid_rst_mosi", o_SPI_MOSI, 0);
    chk("mid_rst_data", o_DATA, 0);
    chk("mid_rst_valid", o_data_valid, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_mrdy", o_MemoryReady, 1);
    reset = 1'b0;
    m_hold = 0;
    do_read(16'hF201);

    // Random mix of sequential and scattered reads with short and long gaps.
    prev = 16'hF201;
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      int          g;
      a = ($urandom_range(0, 1) == 1) ? {4'hF, 12'(prev[11:0] + 12'd1)} : 16'($urandom);
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(300, 360) : $urandom_range(0, 150);
      repeat (g) @(posedge clk);
      #1;
      do_read(a);
      prev = a;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_read_sequencer.md
Name: flash_read_sequencer

Overview:
- SPI-flash read engine that serves 6809 byte reads in the ROM window.
- Converts a 6809 byte-read strobe into a READ (0x03) transaction on the flash SPI pins.
- Holds CS low between reads, so a sequentially next address costs only 8 SCLKs.
- Feeds the data-bus read mux (o_DATA) and drives MRDY low to stretch E/Q until the byte is valid. The top-level flash-writer mux selects these SPI outputs when the FT2232 is not programming.

Parameters:
- CLK_DIV, 1: clk cycles per SCLK half-period (>=1).
- ADDR_BITS, 12: low 6809 address bits forming the flash offset (4 KB window).
- FLASH_BASE, 24'h000000: flash byte address of window offset 0.
- HOLD_CYCLES, 255: idle clk cycles with CS low before auto-deselect.
- CS_HIGH_MIN, 2: minimum clk cycles CS stays high after deselect.

Ports:
- clk  in  1  system clock (internal oscillator)
- reset  in  1  synchronous, active-high reset
- i_enable  in  1  0 = flash owned by writer; abort and deselect
- i_req  in  1  one-cycle read strobe (already synchronised to clk)
- i_ADDRESS_BUS  in  16  6809 address, sampled on i_req
- o_DATA  out  8  last byte read; held until next read completes
- o_data_valid  out  1  one-cycle pulse when o_DATA updates
- o_busy  out  1  high from accepted request until o_data_valid
- o_MemoryReady  out  1  low while a read is outstanding (MRDY)
- o_SPI_CLK  out  1  SCLK, mode 0, idles low
- o_SPI_MOSI  out  1  command/address, MSB first
- o_SPI_CS  out  1  flash chip select, active low
- i_SPI_MISO  in  1  flash data out

Behaviour:
- Reset (synchronous, active-high):
  - o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0.
  - o_DATA=8'h00, o_data_valid=0, o_busy=0, o_MemoryReady=1.
  - State IDLE; continuation invalid; pending request cleared.
  - A reset mid-transfer takes effect on the next edge: CS rises at once, and no CS_HIGH_MIN applies.
- Flash address: FA = FLASH_BASE + i_ADDRESS_BUS[ADDR_BITS-1:0], 24 bits, modulo 2^24.
- States: IDLE, SETUP, CMD (32 bits), DATA (8 bits), HOLD, DESELECT.
- IDLE:
  - CS=1.
  - On i_req go to SETUP; o_busy=1 and o_MemoryReady=0 from the next cycle.
- SETUP: 1 cycle with CS=0, CLK=0, MOSI = bit 31 of {8'h03, FA}.
- Bit timing, in CMD and DATA:
  - Each bit is CLK_DIV cycles with CLK=0, then CLK_DIV cycles with CLK=1.
  - MOSI changes only while CLK=0.
  - MISO is sampled in the last cycle of the CLK=1 phase.
  - MOSI=0 during DATA.
- End of DATA:
  - The cycle after the 8th high phase: CLK=0, o_DATA = shifted byte (MSB first), o_data_valid=1, o_busy=0, o_MemoryReady=1.
  - Go to HOLD with next_FA = FA+1.
- Latency, measured from the i_req cycle (cycle 0):
  - New transaction: o_data_valid in cycle 2+80*CLK_DIV (82 for CLK_DIV=1).
  - Continuation: o_data_valid in cycle 1+16*CLK_DIV (17 for CLK_DIV=1).
- HOLD:
  - CS=0, CLK=0; an idle counter runs.
  - i_req with FA == next_FA goes straight to DATA (continuation).
  - i_req with FA != next_FA goes to DESELECT with the request pending.
  - Counter reaching HOLD_CYCLES goes to DESELECT.
- Window wrap: offset 2^ADDR_BITS-1 followed by offset 0 is not contiguous in FA, so it is a new transaction.
- DESELECT:
  - CS=1 for exactly CS_HIGH_MIN cycles.
  - An i_req here is latched as pending (single slot; a later one overwrites it); o_busy=1, o_MemoryReady=0.
  - On exit go to SETUP if a request is pending, else IDLE.
- i_req while in SETUP/CMD/DATA is ignored; o_busy stays high and the top is responsible for not issuing it.
- i_enable=0 in any state:
  - Next cycle: CS=1, CLK=0, state IDLE, continuation invalid, pending request dropped.
  - o_busy=0, o_MemoryReady=1, o_DATA unchanged, no o_data_valid.
  - i_req is ignored while i_enable=0.
- Simultaneous i_req and HOLD timeout in the same cycle: the request wins; continuation is honoured if FA matches.

Test Plan:
- Reset, then i_req with addr 16'hF000, CLK_DIV=1, flash returning 8'hA5:
  - MOSI shows 03 00 00 00.
  - o_data_valid in cycle 82 with o_DATA=A5.
  - o_MemoryReady low in cycles 1..81.
- Reads at F000 then F001 within HOLD_CYCLES:
  - CS never rises.
  - Second read gives 8 SCLKs, valid 17 cycles after its i_req.
- Read at FFFF then F000:
  - CS high for CS_HIGH_MIN cycles.
  - Full 03 000000 command follows.
- Read at F010, then idle for 255 cycles:
  - CS rises on timeout.
  - Next F011 read issues a full command (no continuation).
- Drop i_enable mid-CMD:
  - CS=1 next cycle, o_busy=0, o_MemoryReady=1, no o_data_valid.
  - A subsequent read after re-enable completes normally.
- Assert reset during DATA:
  - All outputs return to reset values on the next edge.
  - Next i_req starts with SETUP.
